// File: rtl/tdc_echo_pkg.sv
// Shared constants for the multi-echo TDC selection stage: echo modes, error bits, FSM encoding.
package tdc_echo_pkg;

  localparam logic [1:0] ECHO_FIRST  = 2'd0;
  localparam logic [1:0] ECHO_LAST   = 2'd1;
  localparam logic [1:0] ECHO_STRONG = 2'd2;

  localparam int unsigned ERR_SKIP  = 0;
  localparam int unsigned ERR_ORDER = 1;
  localparam int unsigned ERR_BUSY  = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/tdc_echo_qualify.sv
// Combinational qualification of a single echo: width, ordering check and min-width test.
module tdc_echo_qualify #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] rise,
  input  logic [DATA_W-1:0] fall,
  input  logic              valid,
  input  logic [DATA_W-1:0] min_width,
  output logic              qualified,
  output logic [DATA_W-1:0] width,
  output logic              bad_order
);

  logic ordered;

  assign ordered   = fall > rise;
  assign width     = fall - rise;
  assign bad_order = valid && !ordered;
  assign qualified = valid && ordered && (width >= min_width);

endmodule

// File: rtl/tdc_echo_select.sv
// Multi-echo TDC pre-processing: latches a set on new_sig rise, scans echoes one per cycle,
// selects by mode, applies the angle window and tracks angle continuity.
module tdc_echo_select
  import tdc_echo_pkg::*;
#(
  parameter int unsigned N_ECHO    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ANGLE_W   = 16,
  parameter int unsigned ANGLE_MAX = 1053
) (
  input  logic                     i_clk_50m,
  input  logic                     i_rst,
  input  logic [ANGLE_W-1:0]       i_code_angle,
  input  logic                     i_tdc_new_sig,
  input  logic [N_ECHO*DATA_W-1:0] i_rise_data,
  input  logic [N_ECHO*DATA_W-1:0] i_fall_data,
  input  logic [N_ECHO-1:0]        i_echo_valid,
  input  logic [1:0]               i_echo_mode,
  input  logic [DATA_W-1:0]        i_min_width,
  input  logic [ANGLE_W-1:0]       i_start_index,
  input  logic [ANGLE_W-1:0]       i_stop_index,
  input  logic                     i_tdc_switch,
  input  logic                     i_err_clr,
  output logic [ANGLE_W-1:0]       o_code_angle,
  output logic                     o_cal_sig,
  output logic [DATA_W-1:0]        o_rise_data,
  output logic [DATA_W-1:0]        o_fall_data,
  output logic [2:0]               o_echo_idx,
  output logic [3:0]               o_echo_cnt,
  output logic [2:0]               o_error
);

  logic [1:0]               state_q;
  logic                     new_q;
  logic [ANGLE_W-1:0]       angle_q;
  logic [N_ECHO*DATA_W-1:0] rise_q;
  logic [N_ECHO*DATA_W-1:0] fall_q;
  logic [N_ECHO-1:0]        valid_q;
  logic [1:0]               mode_q;
  logic [DATA_W-1:0]        min_width_q;
  logic [ANGLE_W-1:0]       start_q;
  logic [ANGLE_W-1:0]       stop_q;
  logic                     switch_q;
  logic [2:0]               scan_k_q;
  logic                     found_q;
  logic [2:0]               sel_idx_q;
  logic [DATA_W-1:0]        sel_rise_q;
  logic [DATA_W-1:0]        sel_fall_q;
  logic [DATA_W-1:0]        sel_width_q;
  logic [3:0]               cnt_q;
  logic [ANGLE_W-1:0]       prev_angle_q;
  logic                     prev_vld_q;
  logic [2:0]               err_q;

  logic                     new_rise;
  logic [DATA_W-1:0]        cur_rise;
  logic [DATA_W-1:0]        cur_fall;
  logic                     cur_valid;
  logic                     cur_qual;
  logic [DATA_W-1:0]        cur_width;
  logic                     cur_bad;
  logic                     take;
  logic                     count;
  logic                     order_err;
  logic                     scan_last;
  logic                     in_window;
  logic [ANGLE_W-1:0]       angle_exp;
  logic [2:0]               err_set;

  assign new_rise  = i_tdc_new_sig && !new_q;
  assign scan_last = (scan_k_q == 3'(N_ECHO - 1));
  assign in_window = (angle_q >= start_q) && (angle_q <= stop_q);
  assign angle_exp = (prev_angle_q == ANGLE_W'(ANGLE_MAX)) ? '0 : prev_angle_q + 1'b1;

  // Scan counter picks the echo presented to the single shared qualifier.
  always_comb begin
    cur_rise  = '0;
    cur_fall  = '0;
    cur_valid = 1'b0;
    for (int k = 0; k < int'(N_ECHO); k++) begin
      if (scan_k_q == 3'(k)) begin
        cur_rise  = rise_q[k*DATA_W +: DATA_W];
        cur_fall  = fall_q[k*DATA_W +: DATA_W];
        cur_valid = valid_q[k];
      end
    end
  end

  tdc_echo_qualify #(
    .DATA_W (DATA_W)
  ) u_qualify (
    .rise      (cur_rise),
    .fall      (cur_fall),
    .valid     (cur_valid),
    .min_width (min_width_q),
    .qualified (cur_qual),
    .width     (cur_width),
    .bad_order (cur_bad)
  );

  always_comb begin
    take      = 1'b0;
    count     = 1'b0;
    order_err = 1'b0;
    if (state_q == ST_SCAN) begin
      if (switch_q) begin
        count     = cur_qual;
        order_err = cur_bad;
        if (cur_qual) begin
          case (mode_q)
            ECHO_LAST:   take = 1'b1;
            ECHO_STRONG: take = !found_q || (cur_width > sel_width_q);
            default:     take = !found_q;
          endcase
        end
      end else if (scan_k_q == 3'd0) begin
        // Bypass forwards echo 0 unqualified, but ordering is still monitored.
        take      = cur_valid;
        count     = cur_valid;
        order_err = cur_bad;
      end
    end
  end

  always_comb begin
    err_set            = '0;
    err_set[ERR_ORDER] = order_err;
    err_set[ERR_BUSY]  = new_rise && (state_q != ST_IDLE);
    err_set[ERR_SKIP]  = new_rise && (state_q == ST_IDLE) && prev_vld_q &&
                         (i_code_angle != angle_exp);
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      new_q        <= 1'b0;
      angle_q      <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      valid_q      <= '0;
      mode_q       <= '0;
      min_width_q  <= '0;
      start_q      <= '0;
      stop_q       <= '0;
      switch_q     <= 1'b0;
      scan_k_q     <= '0;
      found_q      <= 1'b0;
      sel_idx_q    <= '0;
      sel_rise_q   <= '0;
      sel_fall_q   <= '0;
      sel_width_q  <= '0;
      cnt_q        <= '0;
      prev_angle_q <= '0;
      prev_vld_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      new_q <= i_tdc_new_sig;
      err_q <= (err_q & ~{3{i_err_clr}}) | err_set;
      case (state_q)
        ST_IDLE: begin
          if (new_rise) begin
            state_q      <= ST_SCAN;
            angle_q      <= i_code_angle;
            rise_q       <= i_rise_data;
            fall_q       <= i_fall_data;
            valid_q      <= i_echo_valid;
            mode_q       <= i_echo_mode;
            min_width_q  <= i_min_width;
            start_q      <= i_start_index;
            stop_q       <= i_stop_index;
            switch_q     <= i_tdc_switch;
            scan_k_q     <= '0;
            found_q      <= 1'b0;
            sel_idx_q    <= '0;
            sel_rise_q   <= '0;
            sel_fall_q   <= '0;
            sel_width_q  <= '0;
            cnt_q        <= '0;
            prev_angle_q <= i_code_angle;
            prev_vld_q   <= 1'b1;
          end
        end
        ST_SCAN: begin
          cnt_q <= cnt_q + 4'(count);
          if (take) begin
            found_q     <= 1'b1;
            sel_idx_q   <= scan_k_q;
            sel_rise_q  <= cur_rise;
            sel_fall_q  <= cur_fall;
            sel_width_q <= cur_width;
          end
          if (scan_last) begin
            state_q <= ST_OUT;
          end else begin
            scan_k_q <= scan_k_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      o_code_angle <= '0;
      o_cal_sig    <= 1'b0;
      o_rise_data  <= '0;
      o_fall_data  <= '0;
      o_echo_idx   <= '0;
      o_echo_cnt   <= '0;
    end else begin
      o_cal_sig <= 1'b0;
      if ((state_q == ST_OUT) && in_window) begin
        o_cal_sig    <= 1'b1;
        o_code_angle <= angle_q;
        o_rise_data  <= sel_rise_q;
        o_fall_data  <= sel_fall_q;
        o_echo_idx   <= sel_idx_q;
        o_echo_cnt   <= cnt_q;
      end
    end
  end

  assign o_error = err_q;

endmodule

// File: tb/tb_tdc_echo_select.sv
// Directed self-checking bench for tdc_echo_select with hand-computed expectations.
module tb_tdc_echo_select;

  localparam int N_ECHO  = 4;
  localparam int DATA_W  = 16;
  localparam int ANGLE_W = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [ANGLE_W-1:0]       code_angle;
  logic                     new_sig;
  logic [N_ECHO*DATA_W-1:0] rise_data;
  logic [N_ECHO*DATA_W-1:0] fall_data;
  logic [N_ECHO-1:0]        echo_valid;
  logic [1:0]               echo_mode;
  logic [DATA_W-1:0]        min_width;
  logic [ANGLE_W-1:0]       start_index;
  logic [ANGLE_W-1:0]       stop_index;
  logic                     tdc_switch;
  logic                     err_clr;
  logic [ANGLE_W-1:0]       o_code_angle;
  logic                     o_cal_sig;
  logic [DATA_W-1:0]        o_rise_data;
  logic [DATA_W-1:0]        o_fall_data;
  logic [2:0]               o_echo_idx;
  logic [3:0]               o_echo_cnt;
  logic [2:0]               o_error;

  int n_checks = 0;
  int n_errors = 0;
  int strobes;
  int lat;
  int total;

  always #10 clk = ~clk;

  tdc_echo_select #(
    .N_ECHO    (N_ECHO),
    .DATA_W    (DATA_W),
    .ANGLE_W   (ANGLE_W),
    .ANGLE_MAX (1053)
  ) u_dut (
    .i_clk_50m     (clk),
    .i_rst         (rst),
    .i_code_angle  (code_angle),
    .i_tdc_new_sig (new_sig),
    .i_rise_data   (rise_data),
    .i_fall_data   (fall_data),
    .i_echo_valid  (echo_valid),
    .i_echo_mode   (echo_mode),
    .i_min_width   (min_width),
    .i_start_index (start_index),
    .i_stop_index  (stop_index),
    .i_tdc_switch  (tdc_switch),
    .i_err_clr     (err_clr),
    .o_code_angle  (o_code_angle),
    .o_cal_sig     (o_cal_sig),
    .o_rise_data   (o_rise_data),
    .o_fall_data   (o_fall_data),
    .o_echo_idx    (o_echo_idx),
    .o_echo_cnt    (o_echo_cnt),
    .o_error       (o_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_echo(input int k, input int r, input int f, input logic v);
    rise_data[k*DATA_W +: DATA_W] = DATA_W'(r);
    fall_data[k*DATA_W +: DATA_W] = DATA_W'(f);
    echo_valid[k]                 = v;
  endtask

  task automatic base_echoes();
    set_echo(0, 100, 150, 1'b1);
    set_echo(1, 200, 400, 1'b1);
    set_echo(2, 300, 500, 1'b1);
    set_echo(3, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // new_sig held high for several cycles; only its rising edge should count.
  task automatic run_set(input int angle);
    @(negedge clk);
    code_angle = ANGLE_W'(angle);
    new_sig    = 1'b1;
    strobes    = 0;
    lat        = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) new_sig = 1'b0;
      if (o_cal_sig) begin
        strobes++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  initial begin
    rst = 1'b1; code_angle = '0; new_sig = 1'b0; rise_data = '0; fall_data = '0;
    echo_valid = '0; echo_mode = 2'd2; min_width = 16'd10; start_index = '0;
    stop_index = 16'd1053; tdc_switch = 1'b1; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cal", 32'(o_cal_sig), 0);
    check("rst_err", 32'(o_error), 0);
    check("rst_rise", 32'(o_rise_data), 0);
    check("rst_cnt", 32'(o_echo_cnt), 0);
    check("rst_angle", 32'(o_code_angle), 0);
    rst = 1'b0;

    base_echoes();
    run_set(10);
    check("strong_lat", 32'(lat), 6);
    check("strong_nstrobe", 32'(strobes), 1);
    check("strong_rise", 32'(o_rise_data), 200);
    check("strong_fall", 32'(o_fall_data), 400);
    check("strong_idx", 32'(o_echo_idx), 1);
    check("strong_cnt", 32'(o_echo_cnt), 3);
    check("strong_angle", 32'(o_code_angle), 10);

    echo_mode = 2'd0;
    run_set(11);
    check("first_idx", 32'(o_echo_idx), 0);
    check("first_rise", 32'(o_rise_data), 100);
    check("first_fall", 32'(o_fall_data), 150);
    echo_mode = 2'd1;
    run_set(12);
    check("last_idx", 32'(o_echo_idx), 2);
    check("last_rise", 32'(o_rise_data), 300);
    check("last_fall", 32'(o_fall_data), 500);
    echo_mode = 2'd0;
    set_echo(0, 100, 105, 1'b1);
    run_set(13);
    check("narrow_idx", 32'(o_echo_idx), 1);
    check("narrow_rise", 32'(o_rise_data), 200);
    check("narrow_cnt", 32'(o_echo_cnt), 2);
    echo_mode = 2'd3;
    run_set(14);
    check("mode3_idx", 32'(o_echo_idx), 1);
    check("mode3_cnt", 32'(o_echo_cnt), 2);
    check("seq_err", 32'(o_error), 0);

    tdc_switch = 1'b0;
    echo_mode  = 2'd2;
    set_echo(0, 22052, 22151, 1'b1);
    run_set(15);
    check("byp_rise", 32'(o_rise_data), 22052);
    check("byp_fall", 32'(o_fall_data), 22151);
    check("byp_cnt", 32'(o_echo_cnt), 1);
    check("byp_idx", 32'(o_echo_idx), 0);
    set_echo(0, 22052, 22151, 1'b0);
    run_set(16);
    check("bypz_nstrobe", 32'(strobes), 1);
    check("bypz_rise", 32'(o_rise_data), 0);
    check("bypz_fall", 32'(o_fall_data), 0);
    check("bypz_cnt", 32'(o_echo_cnt), 0);
    check("bypz_angle", 32'(o_code_angle), 16);
    tdc_switch = 1'b1;
    base_echoes();

    start_index = 16'd10;
    stop_index  = 16'd5;
    run_set(17);
    check("inv_win_nstrobe", 32'(strobes), 0);
    check("inv_win_hold", 32'(o_code_angle), 16);
    start_index = '0;
    stop_index  = 16'd1053;

    do_reset();
    run_set(700);
    check("first_unchecked", 32'(o_error), 0);
    run_set(702);
    check("skip_err", 32'(o_error), 1);
    set_echo(1, 8000, 7999, 1'b1);
    run_set(703);
    check("order_err", 32'(o_error), 3);
    check("order_idx", 32'(o_echo_idx), 2);
    check("order_cnt", 32'(o_echo_cnt), 2);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clr", 32'(o_error), 0);
    base_echoes();

    do_reset();
    @(negedge clk);
    code_angle = 16'd5;
    new_sig    = 1'b1;
    strobes    = 0;
    lat        = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) new_sig = 1'b0;
      if (i == 2) new_sig = 1'b1;
      if (i == 4) new_sig = 1'b0;
      if (o_cal_sig) begin
        strobes++;
        if (lat == 0) lat = i;
      end
    end
    check("busy_nstrobe", 32'(strobes), 1);
    check("busy_lat", 32'(lat), 6);
    check("busy_err", 32'(o_error), 4);
    check("busy_rise", 32'(o_rise_data), 200);

    @(negedge clk);
    code_angle = 16'd6;
    new_sig    = 1'b1;
    strobes    = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) new_sig = 1'b0;
      if (i == 3) rst = 1'b1;
      if (i == 4) rst = 1'b0;
      if (o_cal_sig) strobes++;
    end
    check("rstscan_nstrobe", 32'(strobes), 0);
    check("rstscan_angle", 32'(o_code_angle), 0);
    check("rstscan_rise", 32'(o_rise_data), 0);
    check("rstscan_fall", 32'(o_fall_data), 0);
    check("rstscan_idx", 32'(o_echo_idx), 0);
    check("rstscan_cnt", 32'(o_echo_cnt), 0);
    check("rstscan_err", 32'(o_error), 0);

    do_reset();
    start_index = 16'd165;
    stop_index  = 16'd915;
    total       = 0;
    for (int a = 0; a <= 1053; a++) begin
      run_set(a);
      total += strobes;
    end
    run_set(0);
    total += strobes;
    check("sweep_strobes", 32'(total), 751);
    check("sweep_wrap_err", 32'(o_error), 0);
    check("sweep_last_angle", 32'(o_code_angle), 915);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tdc_echo_select.md
Name: tdc_echo_select

Overview:
- Parametrised multi-echo successor to the single-echo TDC pre-processing stage.
- Per encoder angle it takes N_ECHO rise/fall TDC pairs, qualifies each echo, and selects one echo by a run-time mode.
- It applies the start/stop index window and checks angle sequence continuity.
- It emits one distance/RSSI-raw sample per in-window angle toward dist_filter.

Parameters:
- N_ECHO, 4, number of echo rise/fall pairs per angle (1..8).
- DATA_W, 16, width of rise/fall/width values.
- ANGLE_W, 16, encoder angle width.
- ANGLE_MAX, 1053, last angle index before wrap to 0.

Ports:
- i_clk_50m  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_code_angle  in  ANGLE_W  angle of current TDC set.
- i_tdc_new_sig  in  1  new TDC set available; level may last several cycles, and only the rising edge is used.
- i_rise_data  in  N_ECHO*DATA_W  echo k rise time at bits [k*DATA_W +: DATA_W].
- i_fall_data  in  N_ECHO*DATA_W  echo k fall time, same packing.
- i_echo_valid  in  N_ECHO  echo k present.
- i_echo_mode  in  2  0=first, 1=last, 2=strongest (max width), 3=same as 0.
- i_min_width  in  DATA_W  minimum fall-rise for a qualified echo.
- i_start_index  in  ANGLE_W  first angle output (inclusive).
- i_stop_index  in  ANGLE_W  last angle output (inclusive).
- i_tdc_switch  in  1  1=echo selection, 0=bypass echo 0.
- i_err_clr  in  1  clears sticky errors.
- o_code_angle  out  ANGLE_W  angle of output sample.
- o_cal_sig  out  1  one-cycle strobe, output sample valid.
- o_rise_data  out  DATA_W  selected rise.
- o_fall_data  out  DATA_W  selected fall.
- o_echo_idx  out  3  index of selected echo.
- o_echo_cnt  out  4  number of qualified echoes.
- o_error  out  3  sticky errors: [0] angle skip, [1] fall<=rise on a valid echo, [2] new set while busy.

Behaviour:
- Reset (synchronous, high):
  - All outputs and registered state go to 0; FSM goes to IDLE.
  - The angle-check history is cleared.
  - Reset mid-scan aborts the scan with no o_cal_sig.
- FSM IDLE:
  - On the i_tdc_new_sig rising edge, latch angle, all echo data, mode, window and min_width, then go to SCAN.
  - Latched values are used for the whole operation; input changes during SCAN are ignored.
- FSM SCAN:
  - Evaluates one echo per cycle, k=0..N_ECHO-1; after the last echo, go to OUT.
  - Qualified when: valid=1 AND fall>rise (unsigned) AND (fall-rise)>=i_min_width.
  - A valid echo with fall<=rise sets o_error[1] and is not qualified.
  - Mode 0: keep the first qualified echo. Mode 1: keep the last qualified echo.
  - Mode 2: keep the strictly greater width; on a tie, keep the lower index.
  - o_echo_cnt counts qualified echoes.
- FSM OUT:
  - If the latched angle lies in [start,stop], assert o_cal_sig for 1 cycle and update o_code_angle/rise/fall/idx/cnt.
  - Otherwise no strobe and outputs hold.
  - Always return to IDLE.
- Latency: edge-detect cycle, then N_ECHO SCAN cycles, then OUT; o_cal_sig arrives N_ECHO+2 cycles after the input rising edge.
- No qualified echo: strobe still asserted in-window with rise=0, fall=0, idx=0, cnt=0.
- Bypass (i_tdc_switch=0):
  - Echo 0 is passed unqualified if valid; otherwise zeros.
  - cnt = valid[0]; idx=0; same latency.
  - o_error[1] is still checked on echo 0.
- Window: if start>stop, no angle is in window and there is no output.
- Angle check:
  - Expected = previous latched angle + 1, wrapping ANGLE_MAX -> 0.
  - A mismatch sets o_error[0].
  - The first set after reset is not checked.
  - Checked on every accepted set, including out-of-window ones.
- Busy: a rising edge while not IDLE is dropped and sets o_error[2].
- Error clear: o_error bits are sticky until i_err_clr; if set and clear happen in the same cycle, set wins.

Decomposition:
- Package tdc_echo_pkg holds:
  - echo mode constants (ECHO_FIRST/LAST/STRONG);
  - o_error bit indices;
  - FSM state encoding (IDLE, SCAN, OUT).
- Sub-module tdc_echo_qualify (combinational): one rise/fall/valid/min_width in, qualified/width/bad_order out; instantiated once and indexed by the scan counter.

Test Plan:
- Strongest select: mode=2, echoes (rise,fall) = (100,150), (200,400), (300,500), all valid, min_width=10 -> o_rise=200, o_fall=400, idx=1 (tie with echo 2, lower index kept), cnt=3, o_cal_sig 6 cycles (N_ECHO+2) after edge.
- First/last select: same set with mode=0 -> idx=0, rise=100; mode=1 -> idx=2, rise=300; echo 0 with width 5 and min_width=10 in mode 0 -> idx=1, cnt=2.
- Window: start=165, stop=915, sweep angles 0..1053 in sequence -> exactly 751 strobes (165..915); wrap 1053->0 gives no o_error[0].
- Angle skip and order error: angle sequence 700, 702 -> o_error[0]=1; echo 1 valid with rise=8000, fall=7999 -> o_error[1]=1; i_err_clr pulse -> o_error=0.
- Busy and reset: second rising edge 2 cycles after the first -> only one strobe, o_error[2]=1; i_rst asserted during SCAN -> no strobe, all outputs 0.
- Bypass: i_tdc_switch=0, echo 0 = (22052,22151), valid -> rise=22052, fall=22151, cnt=1; echo 0 invalid -> strobe with zeros.
